fetch_arbiter: RTL and testbench
================================

# fetch_arbiter

Round-robin arbiter sharing the single FETCH unit among the four hardware threads. Each thread lane issues a register-window or RAM read/write request. The arbiter selects one lane, drives FETCH's enable/mode/address/data/thread inputs, waits for FETCH's `ack`, and returns read data plus a one-cycle completion pulse to the winning lane. It sits between the per-thread instruction/execute front ends and FETCH. A watchdog abandons transactions that FETCH never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, 1024: max cycles in ISSUE awaiting `f_ack` before abort; must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r_req`  in  4  per-lane request; bit i = thread i.
- `r_write`  in  4  per-lane write mode (1 = write).
- `r_addr`  in  128  per-lane address; lane i = bits [32i+31:32i].
- `r_data_i`  in  128  per-lane write data, same packing.
- `r_data_o`  out  32  read data of the last completed read; shared by all lanes.
- `r_ack`  out  4  one-cycle completion pulse to the granted lane.
- `r_err`  out  4  one-cycle timeout pulse to the granted lane.
- `f_enable`, `f_write_mode`  out  1  to FETCH `f_enable` / `write_mode`.
- `f_addr`, `f_data_i`  out  32  to FETCH `addr` / `data_i`.
- `f_thread`  out  2  to FETCH `thread` = granted lane index.
- `f_data_o`  in  32  from FETCH `data_o`.
- `f_ack`  in  1  from FETCH `ack`.

## Operation
- States: IDLE, ISSUE, RELEASE.
- **IDLE:**
  - If any `r_req` bit is set, grant the first set lane at or after pointer `ptr`, searching upward mod 4.
  - Register that lane's write/addr/data onto the `f_*` outputs and set `f_thread` to the lane index.
  - Set `f_enable=1`, clear the watchdog, and go to ISSUE.
- **ISSUE:**
  - `f_*` outputs are held constant.
  - On a sampled `f_ack=1`:
    - `f_enable←0`.
    - `r_ack[g]←1` for one cycle.
    - If not a write, `r_data_o←f_data_o`.
    - `ptr←g+1` (mod 4).
    - Go to RELEASE.
  - If the watchdog reaches `TIMEOUT_CYCLES`:
    - `f_enable←0`, `r_err[g]←1` for one cycle, `ptr←g+1`, go to RELEASE.
- **RELEASE:**
  - Wait until `f_ack=0` is sampled, then go to IDLE.
  - This keeps a stale ack from completing the next grant.
- **Requester rules:**
  - A lane holds `r_req` and its fields stable until its `r_ack`/`r_err`.
  - Fields are captured at grant, so later changes are ignored.
  - Deasserting `r_req` after grant does not cancel; the pulse is still delivered.
- **Fairness:** a lane just served has the lowest priority next grant. Every requesting lane is served within 4 grants.
- Register-window addresses (≥ `32'hFFFF_FFF0`) and RAM addresses are treated identically. Only FETCH latency differs.
- **`r_data_o`:**
  - Unchanged by writes and timeouts.
  - Consumers sample it in the `r_ack` cycle or later, before the next read completes.

## Timing
- Reset values:
  - `f_enable=0`, `f_write_mode=0`, `f_addr=0`, `f_data_i=0`, `f_thread=0`.
  - `r_ack=0`, `r_err=0`, `r_data_o=0`.
  - `ptr=0`, state IDLE.
- Request sampled at edge E0 → `f_enable=1` after E0.
  - Register-window access: FETCH asserts `ack` after E1. The arbiter samples it at E2, so `r_ack` is high E2–E3.
  - Minimum latency is therefore 2 cycles from request edge to `r_ack`. RAM accesses add FETCH's bus-wait cycles.
- RELEASE lasts ≥1 cycle, typically exactly 1 because FETCH clears `ack` one tick after `f_enable` falls.
- Back-to-back: the next grant issues the cycle after RELEASE exits. Minimum 4 cycles per transaction.
- `r_ack` and `r_err` are mutually exclusive and never high on two lanes at once.
- **Reset mid-operation:**
  - On the reset edge all outputs return to reset values and the in-flight grant is dropped with no pulse.
  - FETCH has no reset, so the arbiter enters RELEASE-equivalent behaviour: after reset it refuses grants until `f_ack=0` is sampled.
- The watchdog counts ISSUE cycles only. The timeout fires on the cycle the count equals `TIMEOUT_CYCLES`.

## Structure
- Shared header `fetch_defs.vh`:
  - state encodings `ST_IDLE`, `ST_ISSUE`, `ST_RELEASE`;
  - `REG_WINDOW_BASE = 32'hFFFF_FFF0`;
  - `N_THREADS = 4`, `THREAD_W = 2`.
- One sub-module, `rr_pick4`: combinational round-robin picker from `req[3:0]` and `ptr[1:0]` → `grant_idx[1:0]`, `grant_valid`.
- Everything else (FSM, watchdog, output registers) lives in `fetch_arbiter`.

## Test plan
- Lane 0 write `32'hFFFF_FFF0←32'h1111_1111`, FETCH model acks 1 tick later:
  - `f_thread=0` and `f_write_mode=1`;
  - `r_ack=4'b0001` exactly 2 cycles after the request edge;
  - `f_enable` low next cycle.
- All four lanes request reads simultaneously, `ptr=0`:
  - grants in order 0,1,2,3, each `r_ack` pulse on the correct bit;
  - `r_data_o` equals each lane's model data (e.g. `32'h1111_1111`, `32'h2222_2222`).
- Lane 2 re-requests immediately after its `r_ack` while lane 3 also requests: lane 3 is granted before lane 2.
- RAM read with FETCH model acking after 6 cycles:
  - `f_*` stable throughout ISSUE;
  - `r_ack` one cycle after the sampled ack;
  - no new grant while `f_ack` is still high in RELEASE.
- FETCH model never acks, `TIMEOUT_CYCLES=8`:
  - `r_err[g]` pulses after 8 ISSUE cycles;
  - `r_ack=0` and `r_data_o` unchanged;
  - the next lane is granted afterwards.
- Assert `rst` while in ISSUE with the model holding `f_ack=1` for 2 more cycles:
  - all outputs are at reset values the cycle after;
  - no grant occurs until the model drops `f_ack`.

Source files
------------

// File: rtl/fetch_arbiter_pkg.sv
// Shared definitions for the FETCH arbiter: thread geometry, FSM encoding,
// register-window base and a lane-unpacking helper.
package fetch_arbiter_pkg;

   localparam int N_THREADS = 4;
   localparam int THREAD_W  = 2;

   localparam logic [31:0] REG_WINDOW_BASE = 32'hFFFF_FFF0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   // Extract lane idx's 32-bit word from a 4x32 packed bus
   function automatic logic [31:0] lane_word(input logic [127:0] bus,
                                             input logic [THREAD_W-1:0] idx);
      return bus[{idx, 5'd0} +: 32];
   endfunction

endpackage

// File: rtl/fetch_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or above ptr,
// searching upward modulo four.
module rr_pick4
   import fetch_arbiter_pkg::*;
(
   input  logic [N_THREADS-1:0] req,
   input  logic [THREAD_W-1:0]  ptr,
   output logic [THREAD_W-1:0]  grant_idx,
   output logic                 grant_valid
);

   logic [N_THREADS-1:0] rot;
   logic [THREAD_W-1:0]  offs;

   // Rotate so that bit 0 is the lane at ptr, then take the lowest set bit
   always_comb begin
      rot = req;
      case (ptr)
         2'd0:    rot = req;
         2'd1:    rot = {req[0], req[3:1]};
         2'd2:    rot = {req[1:0], req[3:2]};
         default: rot = {req[2:0], req[3]};
      endcase
      offs = 2'd0;
      if (rot[0]) begin
         offs = 2'd0;
      end else if (rot[1]) begin
         offs = 2'd1;
      end else if (rot[2]) begin
         offs = 2'd2;
      end else begin
         offs = 2'd3;
      end
      grant_idx   = ptr + offs;
      grant_valid = |req;
   end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing the FETCH unit among four thread lanes, with
// an ISSUE-phase watchdog and a release phase that waits out stale acks.
module fetch_arbiter
   import fetch_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_THREADS-1:0]   r_req,
   input  logic [N_THREADS-1:0]   r_write,
   input  logic [127:0]           r_addr,
   input  logic [127:0]           r_data_i,
   output logic [31:0]            r_data_o,
   output logic [N_THREADS-1:0]   r_ack,
   output logic [N_THREADS-1:0]   r_err,
   output logic                   f_enable,
   output logic                   f_write_mode,
   output logic [31:0]            f_addr,
   output logic [31:0]            f_data_i,
   output logic [THREAD_W-1:0]    f_thread,
   input  logic [31:0]            f_data_o,
   input  logic                   f_ack
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t              state;
   state_t              next_state;
   logic [THREAD_W-1:0] ptr;
   logic [THREAD_W-1:0] grant_idx;
   logic                grant_valid;
   logic [WD_W-1:0]     wd;
   logic                wd_expired;
   logic                start;
   logic                done_ok;
   logic                done_to;

   rr_pick4 u_pick (
      .req         (r_req),
      .ptr         (ptr),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // wd holds the number of ISSUE cycles already spent without an ack
   assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));

   // State register; reset lands in IDLE, whose grant is gated on f_ack low
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (grant_valid && !f_ack) begin
               next_state = ST_ISSUE;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (f_ack || wd_expired) begin
               next_state = ST_RELEASE;
            end else begin
               next_state = ST_ISSUE;
            end
         end
         ST_RELEASE: begin
            if (!f_ack) begin
               next_state = ST_IDLE;
            end else begin
               next_state = ST_RELEASE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Transaction strobes; an ack on the expiry cycle still completes normally
   always_comb begin
      start   = 1'b0;
      done_ok = 1'b0;
      done_to = 1'b0;
      case (state)
         ST_IDLE:  start = grant_valid && !f_ack;
         ST_ISSUE: begin
            done_ok = f_ack;
            done_to = !f_ack && wd_expired;
         end
         default: begin
            start   = 1'b0;
            done_ok = 1'b0;
            done_to = 1'b0;
         end
      endcase
   end

   // Output registers, pointer and watchdog
   always_ff @(posedge clk) begin
      if (rst) begin
         f_enable     <= 1'b0;
         f_write_mode <= 1'b0;
         f_addr       <= 32'd0;
         f_data_i     <= 32'd0;
         f_thread     <= 2'd0;
         r_ack        <= 4'd0;
         r_err        <= 4'd0;
         r_data_o     <= 32'd0;
         ptr          <= 2'd0;
         wd           <= WD_W'(0);
      end else begin
         r_ack <= 4'd0;
         r_err <= 4'd0;
         if (start) begin
            f_enable     <= 1'b1;
            f_write_mode <= r_write[grant_idx];
            f_addr       <= lane_word(r_addr, grant_idx);
            f_data_i     <= lane_word(r_data_i, grant_idx);
            f_thread     <= grant_idx;
            wd           <= WD_W'(0);
         end else if (done_ok) begin
            f_enable <= 1'b0;
            r_ack    <= 4'b0001 << f_thread;
            ptr      <= f_thread + 2'd1;
            if (!f_write_mode) begin
               r_data_o <= f_data_o;
            end else begin
               r_data_o <= r_data_o;
            end
         end else if (done_to) begin
            f_enable <= 1'b0;
            r_err    <= 4'b0001 << f_thread;
            ptr      <= f_thread + 2'd1;
         end else if (state == ST_ISSUE) begin
            wd <= wd + WD_W'(1);
         end else begin
            wd <= wd;
         end
      end
   end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, compared every
// cycle against a transaction-level arbiter model and a behavioural FETCH.
module tb_fetch_arbiter;
   import fetch_arbiter_pkg::*;

   localparam int TO = 8;

   logic         clk;
   logic         rst;
   logic [3:0]   r_req, r_write;
   logic [127:0] r_addr, r_data_i;
   logic [31:0]  r_data_o;
   logic [3:0]   r_ack, r_err;
   logic         f_enable, f_write_mode;
   logic [31:0]  f_addr, f_data_i, f_data_o;
   logic [1:0]   f_thread;
   logic         f_ack;

   fetch_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .r_req(r_req), .r_write(r_write), .r_addr(r_addr),
      .r_data_i(r_data_i), .r_data_o(r_data_o), .r_ack(r_ack), .r_err(r_err),
      .f_enable(f_enable), .f_write_mode(f_write_mode), .f_addr(f_addr),
      .f_data_i(f_data_i), .f_thread(f_thread), .f_data_o(f_data_o), .f_ack(f_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the arbiter (transaction view)
   bit          m_busy, m_drain, m_wr;
   int          m_g, m_cnt, m_ptr;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_ack, m_err;

   // Behavioural FETCH responder
   bit          fe_prev_en, fe_prev_wr, arm_rst, auto_rst;
   logic [31:0] fe_prev_addr, fe_prev_wd;
   int          fe_cnt, fe_hold;
   logic [31:0] mem [logic [31:0]];

   // Requester lanes
   logic [3:0]  pending, rereq;
   bit          rand_en;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic int lat_of(input logic [31:0] a);
      if (a >= REG_WINDOW_BASE) return 0;
      return 1 + int'(a[4:2]) % 6;
   endfunction

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_C3C3;
   endfunction

   // Advance the model by one clock edge using the inputs the DUT just sampled
   task automatic model_edge();
      bit found;
      int idx;
      m_ack = 4'd0;
      m_err = 4'd0;
      if (rst) begin
         m_busy = 0; m_drain = 0; m_wr = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
         m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0;
      end else if (m_busy) begin
         m_cnt++;
         if (f_ack) begin
            m_ack[m_g] = 1'b1;
            if (!m_wr) m_rdata = f_data_o;
            m_ptr = (m_g + 1) % 4; m_busy = 0; m_drain = 1;
         end else if (m_cnt == TO) begin
            m_err[m_g] = 1'b1;
            m_ptr = (m_g + 1) % 4; m_busy = 0; m_drain = 1;
         end
      end else if (m_drain) begin
         if (!f_ack) m_drain = 0;
      end else if (!f_ack && r_req != 4'd0) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (r_req[idx] && !found) begin
               found = 1;
               m_g = idx;
            end
         end
         m_wr    = r_write[m_g];
         m_addr  = r_addr[m_g*32 +: 32];
         m_wdata = r_data_i[m_g*32 +: 32];
         m_busy  = 1;
         m_cnt   = 0;
      end
   endtask

   task automatic compare();
      check_eq("ctl", 64'({f_enable, f_write_mode, f_thread, r_ack, r_err}),
               64'({m_busy, m_wr, 2'(m_g), m_ack, m_err}));
      check_eq("f_addr", 64'(f_addr), 64'(m_addr));
      check_eq("f_data_i", 64'(f_data_i), 64'(m_wdata));
      check_eq("r_data_o", 64'(r_data_o), 64'(m_rdata));
   endtask

   task automatic fetch_edge();
      if (fe_hold > 0) begin
         f_ack = 1'b1; fe_hold--; fe_cnt = 0;
      end else if (fe_prev_en) begin
         if (!f_ack && fe_prev_addr[31:16] != 16'hDEAD) begin
            if (fe_cnt >= lat_of(fe_prev_addr)) begin
               f_ack = 1'b1;
               if (fe_prev_wr) mem[fe_prev_addr] = fe_prev_wd;
               else f_data_o = rd_of(fe_prev_addr);
               if (arm_rst) begin
                  arm_rst = 0; auto_rst = 1; rst = 1'b1; fe_hold = 2;
               end
            end else begin
               fe_cnt++;
            end
         end
      end else begin
         f_ack = 1'b0; fe_cnt = 0; f_data_o = $urandom;
      end
      fe_prev_en = f_enable; fe_prev_wr = f_write_mode;
      fe_prev_addr = f_addr; fe_prev_wd = f_data_i;
   endtask

   task automatic lane_start(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
      r_write[i] = wr;
      r_addr[i*32 +: 32] = a;
      r_data_i[i*32 +: 32] = d;
      r_req[i] = 1'b1;
      pending[i] = 1'b1;
   endtask

   task automatic lanes();
      int sel;
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
         if (r_ack[i] || r_err[i]) begin
            pending[i] = 1'b0;
            r_req[i] = 1'b0;
            if (rereq[i]) begin
               rereq[i] = 1'b0;
               lane_start(i, r_write[i], r_addr[i*32 +: 32], r_data_i[i*32 +: 32]);
            end
         end
         if (rand_en) begin
            if (pending[i] && r_req[i] && f_enable && f_thread == 2'(i) && $urandom_range(5) == 0) begin
               r_req[i] = 1'b0;
               r_addr[i*32 +: 32] = $urandom;
               r_data_i[i*32 +: 32] = $urandom;
            end else if (!pending[i] && $urandom_range(7) == 0) begin
               sel = $urandom_range(39);
               if (sel == 0) a = {16'hDEAD, 16'($urandom)};
               else if (sel < 15) a = REG_WINDOW_BASE + 32'($urandom_range(15));
               else a = {20'h0, 10'($urandom), 2'b00};
               lane_start(i, 1'($urandom), a, $urandom);
            end
         end
         if (rst && pending[i] && !r_req[i]) pending[i] = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_edge();
      compare();
      if (auto_rst) begin
         rst = 1'b0; auto_rst = 0;
      end
      fetch_edge();
      lanes();
   endtask

   task automatic wait_quiet(input int max_cyc);
      int c = 0;
      while ((pending != 4'd0 || m_busy || m_drain) && c < max_cyc) begin
         step();
         c++;
      end
      check_eq("quiet_bound", 64'(c < max_cyc), 64'd1);
      for (int k = 0; k < 3; k++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      rst = 1'b1; r_req = 4'd0; r_write = 4'd0; r_addr = 128'd0; r_data_i = 128'd0;
      f_ack = 1'b0; f_data_o = 32'd0;
      fe_prev_en = 0; fe_prev_wr = 0; fe_prev_addr = 32'd0; fe_prev_wd = 32'd0;
      fe_cnt = 0; fe_hold = 0; arm_rst = 0; auto_rst = 0;
      pending = 4'd0; rereq = 4'd0; rand_en = 0;
      m_busy = 0; m_drain = 0; m_wr = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
      m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0; m_ack = 4'd0; m_err = 4'd0;
      step(); step(); step();
      rst = 1'b0;
      step();

      // lane 0 register-window write
      lane_start(0, 1'b1, 32'hFFFF_FFF0, 32'h1111_1111);
      wait_quiet(50);

      // four simultaneous reads from ptr 0
      do_reset();
      v = 32'h1111_1111;
      for (int i = 0; i < 4; i++) begin
         mem[32'h0000_0100 + 32'(4*i)] = v * 32'(i + 1);
         lane_start(i, 1'b0, 32'h0000_0100 + 32'(4*i), 32'd0);
      end
      wait_quiet(200);

      // lane 2 re-requests at once while lane 3 waits
      lane_start(2, 1'b0, 32'hFFFF_FFF4, 32'd0);
      lane_start(3, 1'b0, 32'hFFFF_FFF8, 32'd0);
      rereq[2] = 1'b1;
      wait_quiet(100);

      // slow RAM read
      lane_start(1, 1'b0, 32'h0000_0014, 32'd0);
      wait_quiet(100);

      // FETCH never acks lane 2; lane 3 follows
      lane_start(2, 1'b0, 32'hDEAD_0010, 32'd0);
      lane_start(3, 1'b0, 32'hFFFF_FFFC, 32'd0);
      wait_quiet(100);

      // reset while FETCH holds ack
      lane_start(0, 1'b0, 32'h0000_0008, 32'd0);
      arm_rst = 1;
      wait_quiet(100);

      rand_en = 1;
      for (int n = 0; n < 3000; n++) step();
      rand_en = 0;
      wait_quiet(2000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
